// File: rtl/enable_conditioner_pkg.sv
// Shared types and width helpers for the enable conditioner.
package enable_conditioner_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDebRise = 2'd1,
        StPressed = 2'd2,
        StDebFall = 2'd3
    } state_t;

    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefRepeatCycles   = 8;

    // Bits needed for a counter that must be able to reach `terminal`.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return $clog2(terminal + 1);
    endfunction

    localparam int unsigned DefDebCntW = cnt_width(DefDebounceCycles);
    localparam int unsigned DefRepCntW = cnt_width(DefRepeatCycles);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is safe to use downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/enable_conditioner.sv
// Turns a raw button/event line into clean one-cycle enable pulses, with optional
// auto-repeat and overflow suppression.
module enable_conditioner
    import enable_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_mode,
    input  logic overflow_in,
    output logic enable,
    output logic btn_level,
    output logic missed
);

    localparam int unsigned DebW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RepW = cnt_width(REPEAT_CYCLES);

    localparam logic [DebW-1:0] DebTerm = DebW'(DEBOUNCE_CYCLES);
    localparam logic [RepW-1:0] RepTerm = RepW'(REPEAT_CYCLES);
    localparam logic [DebW-1:0] DebOne  = DebW'(1);
    localparam logic [RepW-1:0] RepOne  = RepW'(1);

    logic            btn_sync;
    state_t          state_q, state_d;
    logic [DebW-1:0] deb_q, deb_d, deb_inc;
    logic [RepW-1:0] rep_q, rep_d, rep_inc;
    logic            raw_pulse;
    logic            enable_q, btn_level_q, missed_q;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // Counters never exceed their terminal value, so the increments cannot wrap.
    assign deb_inc = deb_q + DebOne;
    assign rep_inc = rep_q + RepOne;

    // Debounce FSM, repeat counter and raw pulse generation.
    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        rep_d     = rep_q;
        raw_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_sync) begin
                    state_d = StDebRise;
                    deb_d   = DebOne;
                end else begin
                    deb_d = '0;
                end
            end
            StDebRise: begin
                if (!btn_sync) begin
                    state_d = StIdle;
                    deb_d   = '0;
                end else if (deb_inc == DebTerm) begin
                    // Press accepted: pulse lands in the first PRESSED cycle.
                    state_d   = StPressed;
                    deb_d     = '0;
                    rep_d     = '0;
                    raw_pulse = 1'b1;
                end else begin
                    deb_d = deb_inc;
                end
            end
            StPressed: begin
                if (!btn_sync) begin
                    state_d = StDebFall;
                    deb_d   = DebOne;
                end else if (repeat_mode) begin
                    if (rep_inc == RepTerm) begin
                        rep_d     = '0;
                        raw_pulse = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
                end
            end
            StDebFall: begin
                if (btn_sync) begin
                    // Bounce back to pressed: no pulse, repeat period restarts.
                    state_d = StPressed;
                    deb_d   = '0;
                    rep_d   = '0;
                end else if (deb_inc == DebTerm) begin
                    state_d = StIdle;
                    deb_d   = '0;
                    rep_d   = '0;
                end else begin
                    deb_d = deb_inc;
                end
            end
            default: begin
                state_d = StIdle;
                deb_d   = '0;
                rep_d   = '0;
            end
        endcase
        if (!repeat_mode) begin
            rep_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            deb_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            rep_q   <= rep_d;
        end
    end

    // Output registers: gated pulse, debounced level, sticky missed flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_q    <= 1'b0;
            btn_level_q <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            enable_q    <= raw_pulse & ~overflow_in;
            btn_level_q <= (state_d == StPressed) || (state_d == StDebFall);
            missed_q    <= missed_q | (raw_pulse & overflow_in);
        end
    end

    assign enable    = enable_q;
    assign btn_level = btn_level_q;
    assign missed    = missed_q;

endmodule
